// File: rtl/gray_coder_pkg.sv
// Shared binary/Gray conversion helpers. The RTL uses bin2gray, and gray2bin
// is the inverse used to check results.
package gray_coder_pkg;

  // Widest word the helpers handle. Narrower callers zero-extend on the way in
  // and truncate on the way out.
  localparam int GRAY_MAX_W = 64;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero-extended upper bits decode to zero, so the full-width walk also works
  // for narrow callers.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_coder_bin2gray_comb.sv
// Combinational parameterized binary-to-Gray encoder (WIDTH <= GRAY_MAX_W).
module bin2gray_comb
  import gray_coder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  logic [GRAY_MAX_W-1:0] bin_ext;
  logic [GRAY_MAX_W-1:0] gray_ext;

  assign bin_ext  = GRAY_MAX_W'(bin);
  assign gray_ext = bin2gray(bin_ext);
  assign gray     = gray_ext[WIDTH-1:0];

endmodule

// File: rtl/gray_coder.sv
// Registered binary-to-Gray encoder. The output is always a flop, with one
// cycle of latency and synchronous active-high reset.
module gray_coder
  import gray_coder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bin_in,
  output logic [WIDTH-1:0] gray_out
);

  logic [WIDTH-1:0] gray_next;

  bin2gray_comb #(
    .WIDTH (WIDTH)
  ) u_enc (
    .bin  (bin_in),
    .gray (gray_next)
  );

  // Reset wins over bin_in. Releasing it registers the current input on the
  // very next edge.
  always_ff @(posedge clk) begin
    if (rst) gray_out <= '0;
    else     gray_out <= gray_next;
  end

endmodule

// File: tb/tb_gray_coder.sv
// Self-checking bench for gray_coder (WIDTH=4): directed reset, sweep, hold,
// wrap and mid-stream reset steps, then random steps checked by a model.
module tb_gray_coder;
  import gray_coder_pkg::*;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] bin_in;
  logic [W-1:0] gray_out;

  int n_checks = 0;
  int n_fails  = 0;

  logic [W-1:0] gray_tbl [N];
  logic [W-1:0] exp_q[$];

  gray_coder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .gray_out (gray_out)
  );

  always #5 clk = ~clk;

  // Reflected-binary construction: each step mirrors the list built so far
  // and sets the new top bit on the mirrored half.
  task automatic build_table();
    int size;
    gray_tbl[0] = '0;
    size = 1;
    for (int k = 0; k < W; k++) begin
      for (int j = 0; j < size; j++) begin
        gray_tbl[2*size-1-j] = gray_tbl[j] | W'(1 << k);
      end
      size = size * 2;
    end
  endtask

  task automatic step(input logic rst_v, input logic [W-1:0] bin_v);
    @(negedge clk);
    rst    = rst_v;
    bin_in = bin_v;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  initial begin
    logic [W-1:0] b;
    logic [W-1:0] prev_g;
    logic [W-1:0] exp_bin;
    logic [W-1:0] wrap_in  [4];
    logic [W-1:0] wrap_exp [4];
    logic [W-1:0] sweep_exp [N];
    int           ones;

    build_table();
    sweep_exp = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                  4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    // Reset with all-ones on the input, then release.
    rst = 1'b1;
    bin_in = '1;
    step(1'b1, 4'b1111);
    check("reset_edge1", gray_out, 4'b0000);
    step(1'b1, 4'b1111);
    check("reset_edge2", gray_out, 4'b0000);
    step(1'b0, 4'b1111);
    check("reset_release", gray_out, 4'b1000);

    // Full sweep against both the literal list and the reflected table.
    for (int i = 0; i < N; i++) begin
      step(1'b0, W'(i));
      check("sweep_list", gray_out, sweep_exp[i]);
      check("sweep_reflect", gray_out, gray_tbl[i]);
    end

    // Hold: the same input on two edges.
    step(1'b0, 4'b1111);
    check("hold_1", gray_out, 4'b1000);
    step(1'b0, 4'b1111);
    check("hold_2", gray_out, 4'b1000);

    // Wrap sequence.
    wrap_in  = '{4'b1111, 4'b0000, 4'b1111, 4'b0101};
    wrap_exp = '{4'b1000, 4'b0000, 4'b1000, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, wrap_in[i]);
      check("wrap", gray_out, wrap_exp[i]);
    end

    // Mid-stream reset while driving 1010.
    step(1'b0, 4'b0011);
    check("pre_reset", gray_out, 4'b0010);
    step(1'b1, 4'b1010);
    check("mid_reset", gray_out, 4'b0000);
    step(1'b0, 4'b1010);
    check("mid_release", gray_out, 4'b1111);

    // Random steps with occasional resets. A queue of inputs models the one-cycle delay.
    exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      b = W'($urandom_range(0, N - 1));
      if ($urandom_range(0, 15) == 0) begin
        step(1'b1, b);
        check("rand_reset", gray_out, 4'b0000);
        exp_q.delete();
      end else begin
        exp_q.push_back(b);
        step(1'b0, b);
        exp_bin = exp_q.pop_front();
        check("rand_table", gray_out, gray_tbl[exp_bin]);
        check("rand_decode", W'(gray2bin(GRAY_MAX_W'(gray_out))), exp_bin);
      end
    end

    // Consecutive binary values: Gray codes differ in exactly one bit, including across the wrap.
    b = W'($urandom_range(0, N - 1));
    step(1'b0, b);
    check("adj_start", gray_out, gray_tbl[b]);
    prev_g = gray_out;
    for (int i = 0; i < 40; i++) begin
      b = b + 1'b1;
      step(1'b0, b);
      ones = $countones(gray_out ^ prev_g);
      n_checks++;
      assert (ones == 1) else begin
        n_fails++;
        $error("FAIL adj_one_bit: observed %0d changed bits expected 1 (bin %b)", ones, b);
      end
      prev_g = gray_out;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
